multi_freq_counter: RTL and testbench
=====================================

Name: multi_freq_counter

Overview:
- Multi-channel frequency/event counter running entirely in the reference-clock domain.
- NUM_CH asynchronous, low-rate signals (PPS, tach, divided refclks, lock flags) are synchronised, edge-detected and counted over a runtime-programmable gate window.
- At each window end, all channel counts are snapshotted together with overflow and dead-signal flags.
- Successor to the single-channel fixed-1 s counter: adds channel count, width, gate-length and status generalisation.

Parameters:
- NUM_CH, 4, number of measured input channels (1..32)
- CNT_W, 32, per-channel edge counter width
- GATE_W, 32, width of gate-period input/counter
- NBSYNC, 3, synchroniser stages per channel (>=2)

Ports:
- i_RefClk_p  in  1  reference clock; all logic on its rising edge
- i_Rst_n_p  in  1  synchronous active-low reset
- iv_Signal_p  in  NUM_CH  asynchronous measured signals, bit k = channel k
- iv_GatePeriod_p  in  GATE_W  window length in i_RefClk_p cycles
- i_Clear_p  in  1  synchronous restart of current window and statistics
- o_Update_p  out  1  one-cycle pulse: new snapshot available
- o_Update_Toggle_p  out  1  toggles on every snapshot, for CDC consumers
- o_Valid_p  out  1  high once the first full window completes
- ov_Count_p  out  NUM_CH*CNT_W  snapshot counts, channel k at [k*CNT_W +: CNT_W]
- ov_Ovf_p  out  NUM_CH  channel count saturated during snapshotted window
- ov_Dead_p  out  NUM_CH  channel saw zero rising edges in snapshotted window
- ov_Min_p  out  NUM_CH*CNT_W  minimum snapshot per channel (optional feature)
- ov_Max_p  out  NUM_CH*CNT_W  maximum snapshot per channel (optional feature)

Behaviour:
- Reset (i_Rst_n_p=0 at clock edge):
  - Clears all synchroniser stages, edge registers, channel counters, gate counter and latched period.
  - Drives every output to 0; ov_Min_p resets to all-ones internally but is reported as 0 until o_Valid_p=1.
- Reset mid-window discards the partial window; no o_Update_p is issued.
- Per channel: NBSYNC-stage synchroniser, then a previous-value register; rising edge = sync & ~prev.
  - Latency from input edge to counter increment: NBSYNC+1 cycles.
  - Measurable only if high and low phases are each > 1 ref cycle.
- Gate period:
  - iv_GatePeriod_p is latched at window start; changes mid-window take effect at the next window.
  - Latched values < 2 are clamped to 2.
- Gate counter runs 0 .. P-1. The cycle where gate == P-1 is the terminal cycle. On the terminal cycle:
  - ov_Count_p[k] <= cnt[k] + edge[k], saturating at 2^CNT_W-1.
  - ov_Ovf_p[k] <= sticky saturation flag; ov_Dead_p[k] <= (snapshot value == 0).
  - Channel counters and sticky flags clear to 0; an edge on the terminal cycle belongs to the closing window.
  - o_Update_p pulses high for exactly one cycle, coincident with the new outputs; o_Update_Toggle_p inverts; o_Valid_p sets and stays high until reset.
- Window length is exactly P cycles; windows are back-to-back with no dead cycles.
- Saturation: a counter at all-ones holds; the sticky overflow flag sets on any attempted increment past all-ones.
- i_Clear_p=1:
  - Gate counter, channel counters, sticky flags and min/max restart as if from reset; the period is re-latched.
  - Snapshot outputs and o_Valid_p hold their values; no update is issued that cycle.
  - Clear on the terminal cycle wins: no snapshot is taken.
- Gate counter wraps only via the terminal condition; it never overflows GATE_W.

Optional Feature:
- Macro: MULTI_FREQ_COUNTER_MINMAX_EN
- Defined:
  - At each snapshot, per channel: min <= min(min, snapshot) and max <= max(max, snapshot).
  - First snapshot after reset or clear initialises both min and max to that snapshot.
  - ov_Min_p and ov_Max_p are updated on the same cycle as ov_Count_p.
- Undefined: no min/max registers are built; ov_Min_p and ov_Max_p are tied to 0.

Test Plan:
- Reset, P=100, NUM_CH=4, channel 0 driven at ref/10 -> first o_Update_p at cycle 100 after reset release; count0=10, counts1..3=0, ov_Dead_p=4'b1110, o_Valid_p=1.
- P=1000, channel 2 toggling every 4 cycles (period 8) -> count2=125 every window; o_Update_p exactly every 1000 cycles; o_Update_Toggle_p alternates.
- CNT_W=4, P=100, channel 1 at ref/4 -> count1=15, ov_Ovf_p[1]=1; next window with input stopped -> count1=0, ov_Ovf_p[1]=0, ov_Dead_p[1]=1.
- Change P from 100 to 50 at gate=30 -> current window still 100 cycles, following windows 50; set P=0 -> windows of 2 cycles.
- Assert i_Clear_p at gate=60 of a P=100 window, and separately on the terminal cycle -> no update that cycle, next update 100 cycles after clear, previous outputs held.
- With MULTI_FREQ_COUNTER_MINMAX_EN, channel 0 rates giving counts 20, 5, 30 -> min 20/5/5, max 20/20/30. Without the macro, both ports read 0.

Source files
------------

// File: rtl/multi_freq_counter.sv
// Multi-channel frequency/event counter: synchronises NUM_CH async inputs, counts rising
// edges over a programmable gate window and snapshots them. Min/max tracking: MULTI_FREQ_COUNTER_MINMAX_EN.
module multi_freq_counter #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int GATE_W = 32,
    parameter int NBSYNC = 3
) (
    input  logic                       i_RefClk_p,
    input  logic                       i_Rst_n_p,
    input  logic [NUM_CH-1:0]          iv_Signal_p,
    input  logic [GATE_W-1:0]          iv_GatePeriod_p,
    input  logic                       i_Clear_p,
    output logic                       o_Update_p,
    output logic                       o_Update_Toggle_p,
    output logic                       o_Valid_p,
    output logic [NUM_CH*CNT_W-1:0]    ov_Count_p,
    output logic [NUM_CH-1:0]          ov_Ovf_p,
    output logic [NUM_CH-1:0]          ov_Dead_p,
    output logic [NUM_CH*CNT_W-1:0]    ov_Min_p,
    output logic [NUM_CH*CNT_W-1:0]    ov_Max_p
);

    localparam logic [GATE_W-1:0] MIN_PERIOD = GATE_W'(2);

    logic [NUM_CH-1:0] sync_q [NBSYNC];
    logic [NUM_CH-1:0] prev_q;
    logic [NUM_CH-1:0] rise;

    logic [GATE_W-1:0] gate_q;
    logic [GATE_W-1:0] period_q;
    logic              terminal;
    logic              take_snap;

    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [NUM_CH-1:0] sat_q;
    logic [CNT_W-1:0]  next_cnt [NUM_CH];
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] snap_ovf;

    always_ff @(posedge i_RefClk_p) begin
        if (!i_Rst_n_p) begin
            for (int i = 0; i < NBSYNC; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= iv_Signal_p;
            for (int i = 1; i < NBSYNC; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_q[NBSYNC-1];
        end
    end

    assign rise = sync_q[NBSYNC-1] & ~prev_q;

    // Gate 0 never terminates (period >= 2), so a stale period_q there is harmless.
    assign terminal  = (gate_q != '0) && (gate_q == period_q - GATE_W'(1));
    assign take_snap = terminal && !i_Clear_p;

    // Period is latched on the first cycle of every window, clamped to at least 2.
    always_ff @(posedge i_RefClk_p) begin
        if (!i_Rst_n_p) begin
            gate_q   <= '0;
            period_q <= '0;
        end else if (i_Clear_p) begin
            gate_q <= '0;
        end else begin
            if (gate_q == '0)
                period_q <= (iv_GatePeriod_p < MIN_PERIOD) ? MIN_PERIOD : iv_GatePeriod_p;
            if (terminal)
                gate_q <= '0;
            else
                gate_q <= gate_q + GATE_W'(1);
        end
    end

    // Saturating next count; an edge on the terminal cycle still belongs to the closing window.
    always_comb begin
        full     = '0;
        snap_ovf = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            next_cnt[k] = cnt_q[k];
            full[k]     = &cnt_q[k];
            if (!full[k])
                next_cnt[k] = cnt_q[k] + CNT_W'(rise[k]);
            snap_ovf[k] = sat_q[k] | (full[k] & rise[k]);
        end
    end

    always_ff @(posedge i_RefClk_p) begin
        if (!i_Rst_n_p || i_Clear_p || terminal) begin
            for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
            sat_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= next_cnt[k];
            sat_q <= snap_ovf;
        end
    end

    always_ff @(posedge i_RefClk_p) begin
        if (!i_Rst_n_p) begin
            o_Update_p        <= 1'b0;
            o_Update_Toggle_p <= 1'b0;
            o_Valid_p         <= 1'b0;
            ov_Count_p        <= '0;
            ov_Ovf_p          <= '0;
            ov_Dead_p         <= '0;
        end else begin
            o_Update_p <= take_snap;
            if (take_snap) begin
                o_Update_Toggle_p <= ~o_Update_Toggle_p;
                o_Valid_p         <= 1'b1;
                ov_Ovf_p          <= snap_ovf;
                for (int k = 0; k < NUM_CH; k++) begin
                    ov_Count_p[k*CNT_W +: CNT_W] <= next_cnt[k];
                    ov_Dead_p[k]                 <= (next_cnt[k] == '0);
                end
            end
        end
    end

`ifdef MULTI_FREQ_COUNTER_MINMAX_EN
    logic [CNT_W-1:0]         min_q [NUM_CH];
    logic [CNT_W-1:0]         max_q [NUM_CH];
    logic [CNT_W-1:0]         new_min [NUM_CH];
    logic [CNT_W-1:0]         new_max [NUM_CH];
    logic [NUM_CH*CNT_W-1:0]  min_out_q;
    logic [NUM_CH*CNT_W-1:0]  max_out_q;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            new_min[k] = (next_cnt[k] < min_q[k]) ? next_cnt[k] : min_q[k];
            new_max[k] = (next_cnt[k] > max_q[k]) ? next_cnt[k] : max_q[k];
        end
    end

    // Tracking state restarts on clear, but the reported values hold until the next snapshot.
    always_ff @(posedge i_RefClk_p) begin
        if (!i_Rst_n_p) begin
            for (int k = 0; k < NUM_CH; k++) begin
                min_q[k] <= '1;
                max_q[k] <= '0;
            end
            min_out_q <= '0;
            max_out_q <= '0;
        end else if (i_Clear_p) begin
            for (int k = 0; k < NUM_CH; k++) begin
                min_q[k] <= '1;
                max_q[k] <= '0;
            end
        end else if (terminal) begin
            for (int k = 0; k < NUM_CH; k++) begin
                min_q[k]                    <= new_min[k];
                max_q[k]                    <= new_max[k];
                min_out_q[k*CNT_W +: CNT_W] <= new_min[k];
                max_out_q[k*CNT_W +: CNT_W] <= new_max[k];
            end
        end
    end

    assign ov_Min_p = min_out_q;
    assign ov_Max_p = max_out_q;
`else
    assign ov_Min_p = '0;
    assign ov_Max_p = '0;
`endif

endmodule

// File: tb/tb_multi_freq_counter.sv
// Directed bench for multi_freq_counter: a 32-bit and a 4-bit counter instance share
// the same stimulus so saturation can be observed alongside exact counts.
module tb_multi_freq_counter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   sig = 4'b0000;
    logic [31:0]  gate_period = 32'd100;
    logic         clear = 1'b0;

    logic         upd_a, tog_a, valid_a, upd_b, tog_b, valid_b;
    logic [127:0] count_a, min_a, max_a;
    logic [15:0]  count_b, min_b, max_b;
    logic [3:0]   ovf_a, dead_a, ovf_b, dead_b;

    int           half [4];
    int           phase [4];
    logic [3:0]   lvl = 4'b0000;

    int           checks = 0;
    int           failures = 0;
    logic         exp_toggle = 1'b0;
    int           n;

    multi_freq_counter #(.NUM_CH(4), .CNT_W(32), .GATE_W(32), .NBSYNC(3)) dut_a (
        .i_RefClk_p(clk), .i_Rst_n_p(rst_n), .iv_Signal_p(sig),
        .iv_GatePeriod_p(gate_period), .i_Clear_p(clear),
        .o_Update_p(upd_a), .o_Update_Toggle_p(tog_a), .o_Valid_p(valid_a),
        .ov_Count_p(count_a), .ov_Ovf_p(ovf_a), .ov_Dead_p(dead_a),
        .ov_Min_p(min_a), .ov_Max_p(max_a)
    );

    multi_freq_counter #(.NUM_CH(4), .CNT_W(4), .GATE_W(32), .NBSYNC(3)) dut_b (
        .i_RefClk_p(clk), .i_Rst_n_p(rst_n), .iv_Signal_p(sig),
        .iv_GatePeriod_p(gate_period), .i_Clear_p(clear),
        .o_Update_p(upd_b), .o_Update_Toggle_p(tog_b), .o_Valid_p(valid_b),
        .ov_Count_p(count_b), .ov_Ovf_p(ovf_b), .ov_Dead_p(dead_b),
        .ov_Min_p(min_b), .ov_Max_p(max_b)
    );

    always #5 clk = ~clk;

    // Square-wave sources: channel k toggles every half[k] cycles, held low while half[k] is 0.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (half[k] == 0) begin
                    lvl[k]   = 1'b0;
                    phase[k] = 0;
                end else begin
                    phase[k] = phase[k] + 1;
                    if (phase[k] >= half[k]) begin
                        lvl[k]   = ~lvl[k];
                        phase[k] = 0;
                    end
                end
            end
            sig = lvl;
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] period, input logic clr);
        gate_period = period;
        clear       = clr;
    endtask

    task automatic waitUpdate(input int limit, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!upd_a && cycles < limit);
    endtask

    task automatic checkWindow(input string tag, input int cycles, input int exp_cycles);
        exp_toggle = ~exp_toggle;
        checkOutput({tag, "_upd"}, upd_a, 1'b1);
        checkOutput({tag, "_upd_b"}, upd_b, 1'b1);
        checkOutput({tag, "_cycles"}, cycles, exp_cycles);
        checkOutput({tag, "_toggle"}, tog_a, exp_toggle);
        checkOutput({tag, "_valid"}, valid_a, 1'b1);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            half[k]  = 0;
            phase[k] = 0;
        end
        applyStimulus(32'd100, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("rst_upd", upd_a, 1'b0);
        checkOutput("rst_toggle", tog_a, 1'b0);
        checkOutput("rst_valid", valid_a, 1'b0);
        checkOutput("rst_count", count_a, 128'd0);
        checkOutput("rst_ovf", ovf_a, 4'd0);
        checkOutput("rst_dead", dead_a, 4'd0);
        checkOutput("rst_min", min_a, 128'd0);
        checkOutput("rst_max", max_a, 128'd0);

        // First window after reset: channel 0 at ref/10.
        #1;
        rst_n   = 1'b1;
        half[0] = 5;
        waitUpdate(110, n);
        checkWindow("w1", n, 100);
        checkOutput("w1_count0", count_a[31:0], 32'd10);
        checkOutput("w1_count123", count_a[127:32], 96'd0);
        checkOutput("w1_dead", dead_a, 4'b1110);
        checkOutput("w1_ovf", ovf_a, 4'b0000);
        checkOutput("w1_count0_b", count_b[3:0], 4'd10);
        @(posedge clk);
        #1;
        checkOutput("w1_pulse_end", upd_a, 1'b0);

        // Period change at gate 30 only affects the following window.
        repeat (29) @(posedge clk);
        #2;
        applyStimulus(32'd50, 1'b0);
        half[2] = 4;
        waitUpdate(80, n);
        checkWindow("w2", n, 70);
        checkOutput("w2_count0", count_a[31:0], 32'd10);
        waitUpdate(60, n);
        checkWindow("w3", n, 50);
        checkOutput("w3_count0", count_a[31:0], 32'd5);

        // Period 0 clamps to 2-cycle windows.
        #1;
        applyStimulus(32'd0, 1'b0);
        waitUpdate(10, n);
        checkWindow("w4", n, 2);
        waitUpdate(10, n);
        checkWindow("w5", n, 2);

        #1;
        applyStimulus(32'd1000, 1'b0);
        for (int w = 0; w < 2; w++) begin
            waitUpdate(1010, n);
            checkWindow("wk", n, 1000);
            checkOutput("wk_count0", count_a[31:0], 32'd100);
            checkOutput("wk_count2", count_a[95:64], 32'd125);
            checkOutput("wk_dead", dead_a, 4'b1010);
            checkOutput("wk_ovf", ovf_a, 4'b0000);
            checkOutput("wk_count0_b", count_b[3:0], 4'd15);
            checkOutput("wk_count2_b", count_b[11:8], 4'd15);
            checkOutput("wk_ovf_b", ovf_b, 4'b0101);
        end

        // Saturation on the 4-bit instance, then a fully idle window.
        #1;
        applyStimulus(32'd100, 1'b0);
        half[1] = 2;
        repeat (80) @(posedge clk);
        #2;
        for (int k = 0; k < 4; k++) half[k] = 0;
        waitUpdate(30, n);
        checkWindow("sat", n, 20);
        checkOutput("sat_count1_b", count_b[7:4], 4'd15);
        checkOutput("sat_ovf_b", ovf_b, 4'b0010);
        checkOutput("sat_ovf_a", ovf_a, 4'b0000);
        waitUpdate(110, n);
        checkWindow("idle", n, 100);
        checkOutput("idle_count1_b", count_b[7:4], 4'd0);
        checkOutput("idle_ovf_b", ovf_b, 4'b0000);
        checkOutput("idle_dead_b", dead_b, 4'b1111);
        checkOutput("idle_count_a", count_a, 128'd0);
        checkOutput("idle_dead_a", dead_a, 4'b1111);

        // Clear at gate 60: outputs hold, next update 100 cycles after clear.
        #1;
        half[0] = 5;
        waitUpdate(110, n);
        checkWindow("pre_clr", n, 100);
        checkOutput("pre_clr_count0", count_a[31:0], 32'd10);
        checkOutput("pre_clr_dead", dead_a, 4'b1110);
        repeat (60) @(posedge clk);
        #2;
        applyStimulus(32'd100, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("clr_upd", upd_a, 1'b0);
        checkOutput("clr_hold_count0", count_a[31:0], 32'd10);
        checkOutput("clr_hold_valid", valid_a, 1'b1);
        #1;
        applyStimulus(32'd100, 1'b0);
        waitUpdate(110, n);
        checkWindow("post_clr", n, 100);
        checkOutput("post_clr_count0", count_a[31:0], 32'd10);

        // Clear on the terminal cycle suppresses that snapshot.
        repeat (99) @(posedge clk);
        #2;
        applyStimulus(32'd100, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("tclr_upd", upd_a, 1'b0);
        checkOutput("tclr_toggle", tog_a, exp_toggle);
        checkOutput("tclr_count0", count_a[31:0], 32'd10);
        #1;
        applyStimulus(32'd100, 1'b0);
        waitUpdate(110, n);
        checkWindow("post_tclr", n, 100);
        checkOutput("post_tclr_count0", count_a[31:0], 32'd10);

        // Counts 20, 5, 30 on channel 0 via gate lengths 200, 50, 300 after a clear.
        #1;
        applyStimulus(32'd200, 1'b1);
        @(posedge clk);
        #2;
        applyStimulus(32'd200, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        applyStimulus(32'd50, 1'b0);
        waitUpdate(200, n);
        checkWindow("mm1", n, 190);
        checkOutput("mm1_count0", count_a[31:0], 32'd20);
`ifdef MULTI_FREQ_COUNTER_MINMAX_EN
        checkOutput("mm1_min0", min_a[31:0], 32'd20);
        checkOutput("mm1_max0", max_a[31:0], 32'd20);
`else
        checkOutput("mm1_min", min_a, 128'd0);
        checkOutput("mm1_max", max_a, 128'd0);
`endif
        repeat (10) @(posedge clk);
        #2;
        applyStimulus(32'd300, 1'b0);
        waitUpdate(50, n);
        checkWindow("mm2", n, 40);
        checkOutput("mm2_count0", count_a[31:0], 32'd5);
`ifdef MULTI_FREQ_COUNTER_MINMAX_EN
        checkOutput("mm2_min0", min_a[31:0], 32'd5);
        checkOutput("mm2_max0", max_a[31:0], 32'd20);
`else
        checkOutput("mm2_min", min_a, 128'd0);
        checkOutput("mm2_max", max_a, 128'd0);
`endif
        waitUpdate(310, n);
        checkWindow("mm3", n, 300);
        checkOutput("mm3_count0", count_a[31:0], 32'd30);
`ifdef MULTI_FREQ_COUNTER_MINMAX_EN
        checkOutput("mm3_min0", min_a[31:0], 32'd5);
        checkOutput("mm3_max0", max_a[31:0], 32'd30);
`else
        checkOutput("mm3_min", min_a, 128'd0);
        checkOutput("mm3_max", max_a, 128'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
